act_sram_writer: RTL and testbench

ACT_SRAM_WRITER -- requirements
Module: act_sram_writer

---
 rtl/act_sram_pkg.sv | 18 +
 rtl/act_lane_packer.sv | 61 ++++++
 rtl/act_sram_writer.sv | 134 +++++++++++++
 tb/tb_act_sram_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_sram_pkg.sv
// Shared sizing defaults and FSM encoding for the activation SRAM writer.
// Every act_sram_* file imports this package. It has no logic of its own.
package act_sram_pkg;

  localparam int CH_NUM_DEF       = 4;
  localparam int ACT_PER_ADDR_DEF = 4;
  localparam int BW_PER_ACT_DEF   = 12;
  localparam int DEPTH_DEF        = 18;
  localparam int ADDR_W           = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_t;

endpackage

// File: rtl/act_lane_packer.sv
// Collects one SRAM word of activations lane by lane and derives the per-lane keep mask.
// A pushed beat is visible on o_data the next cycle. The caller gates i_push, so this block never stalls.
module act_lane_packer
  import act_sram_pkg::*;
#(
  parameter int LANES = CH_NUM_DEF * ACT_PER_ADDR_DEF,
  parameter int BW    = BW_PER_ACT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_push,
  input  logic [BW-1:0]       i_data,
  output logic [LANES*BW-1:0] o_data,
  output logic [LANES-1:0]    o_mask,
  output logic                o_last_lane
);

  localparam int CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [LANES*BW-1:0] r_buf;
  logic [LANES-1:0]    w_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_push) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Clearing the whole word keeps lanes that are never filled at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (i_clr) begin
      r_buf <= '0;
    end else if (i_push) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          r_buf[k*BW +: BW] <= i_data;
        end
      end
    end
  end

  always_comb begin
    w_mask = '1;
    for (int k = 0; k < LANES; k++) begin
      w_mask[k] = (CNT_W'(k) >= r_cnt);
    end
  end

  assign o_data      = r_buf;
  assign o_mask      = w_mask;
  assign o_last_lane = (r_cnt == CNT_W'(LANES - 1));

endmodule

// File: rtl/act_sram_writer.sv
// Packs streamed activations into SRAM words and writes addresses 0..DEPTH-1, or stops early on in_last.
// The write comes 1 clock after the final beat of a word. in_ready is low outside FILL, so the stream stalls during each write.
module act_sram_writer
  import act_sram_pkg::*;
#(
  parameter int CH_NUM       = CH_NUM_DEF,
  parameter int ACT_PER_ADDR = ACT_PER_ADDR_DEF,
  parameter int BW_PER_ACT   = BW_PER_ACT_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     in_valid,
  input  logic [BW_PER_ACT-1:0]                    in_data,
  input  logic                                     in_last,
  output logic                                     in_ready,
  output logic                                     sram_csb,
  output logic                                     sram_wsb,
  output logic [ADDR_W-1:0]                        sram_waddr,
  output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata,
  output logic [CH_NUM*ACT_PER_ADDR-1:0]           sram_wordmask,
  output logic                                     busy,
  output logic                                     done
);

  localparam int LANES = CH_NUM * ACT_PER_ADDR;

  wr_state_t              r_state;
  wr_state_t              w_state_nxt;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_last_seen;
  logic                   w_accept;
  logic                   w_clr;
  logic                   w_addr_clr;
  logic                   w_addr_inc;
  logic                   w_last_lane;
  logic [LANES*BW_PER_ACT-1:0] w_pk_data;
  logic [LANES-1:0]       w_pk_mask;

  act_lane_packer #(
    .LANES (LANES),
    .BW    (BW_PER_ACT)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_push      (w_accept),
    .i_data      (in_data),
    .o_data      (w_pk_data),
    .o_mask      (w_pk_mask),
    .o_last_lane (w_last_lane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_clr       = 1'b0;
    w_addr_clr  = 1'b0;
    w_addr_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FILL;
          w_clr       = 1'b1;
          w_addr_clr  = 1'b1;
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (in_last || w_last_lane) begin
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        w_clr = 1'b1;
        // The final address is not incremented, so the address never wraps.
        if (r_last_seen || (r_addr == ADDR_W'(DEPTH - 1))) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FILL;
          w_addr_inc  = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_addr_clr) begin
      r_addr <= '0;
    end else if (w_addr_inc) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_seen <= 1'b0;
    end else if (w_clr) begin
      r_last_seen <= 1'b0;
    end else if (w_accept && in_last) begin
      r_last_seen <= 1'b1;
    end
  end

  // The SRAM strobes are decoded from the state, so a reset during WRITE drops the write at once.
  assign in_ready      = (r_state == ST_FILL);
  assign sram_csb      = (r_state != ST_WRITE);
  assign sram_wsb      = (r_state != ST_WRITE);
  assign sram_waddr    = r_addr;
  assign sram_wdata    = w_pk_data;
  assign sram_wordmask = (r_state == ST_WRITE) ? w_pk_mask : '1;
  assign busy          = (r_state == ST_FILL) || (r_state == ST_WRITE);
  assign done          = (r_state == ST_DONE);

endmodule

// File: tb/tb_act_sram_writer.sv
// Self-checking bench for act_sram_writer.
// Frame scenarios come from a table. A reference model queues the expected SRAM writes as beats are accepted.
module tb_act_sram_writer;

  localparam int LANES = 16;
  localparam int BW    = 12;
  localparam int W     = LANES * BW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [BW-1:0]    in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             sram_csb;
  logic             sram_wsb;
  logic [4:0]       sram_waddr;
  logic [W-1:0]     sram_wdata;
  logic [LANES-1:0] sram_wordmask;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  act_sram_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .sram_csb      (sram_csb),
    .sram_wsb      (sram_wsb),
    .sram_waddr    (sram_waddr),
    .sram_wdata    (sram_wdata),
    .sram_wordmask (sram_wordmask),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {
    logic [4:0]       addr;
    logic [W-1:0]     data;
    logic [LANES-1:0] mask;
  } wr_t;

  typedef struct {
    int               n;
    int               last_idx;
    int               gap;
    int               nwr;
    logic [LANES-1:0] lmask;
    logic [BW-1:0]    l15;
  } vec_t;

  wr_t              exp_q[$];
  vec_t             vecs[5];
  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc = 0;
  int               writes_seen = 0;
  int               last_wr_cyc = 0;
  int               done_cyc = 0;
  logic [LANES-1:0] last_mask = '1;
  logic [W-1:0]     a0_data = '0;
  int               maddr = 0;
  int               mk = 0;
  logic [W-1:0]     mbuf = '0;
  bit               timed_out = 1'b0;

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && !sram_csb && !sram_wsb) begin
      writes_seen++;
      last_wr_cyc = cyc;
      last_mask   = sram_wordmask;
      if (sram_waddr == 5'd0) a0_data = sram_wdata;
      chk("wr_expected", W'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", W'(sram_waddr), W'(e.addr));
        chk("wr_data", sram_wdata, e.data);
        chk("wr_mask", W'(sram_wordmask), W'(e.mask));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic model_reset();
    maddr = 0;
    mk    = 0;
    mbuf  = '0;
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic l);
    int budget;
    logic [31:0] m;
    budget   = 50;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      chk("beat_accept_timeout", W'(in_ready), 1);
      timed_out = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      mbuf[mk*BW +: BW] = d;
      mk++;
      if (mk == LANES || l) begin
        m = 32'hFFFF << mk;
        exp_q.push_back('{addr: maddr[4:0], data: mbuf, mask: m[LANES-1:0]});
        maddr++;
        mk   = 0;
        mbuf = '0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive_beats(input int first, input int count, input int last_idx, input int gap_max);
    for (int b = first; b < first + count; b++) begin
      if (timed_out) break;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) step();
      send_beat(BW'(b), b == last_idx);
    end
  endtask

  task automatic wait_done();
    int budget;
    budget = 40;
    @(negedge clk);
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("done_seen", W'(done), 1);
    if (done) done_cyc = cyc;
    step();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, W'(in_ready), 0);
    chk({tag, "_csb"}, W'(sram_csb), 1);
    chk({tag, "_wsb"}, W'(sram_wsb), 1);
    chk({tag, "_waddr"}, W'(sram_waddr), 0);
    chk({tag, "_wdata"}, sram_wdata, 0);
    chk({tag, "_mask"}, W'(sram_wordmask), W'(16'hFFFF));
    chk({tag, "_busy"}, W'(busy), 0);
    chk({tag, "_done"}, W'(done), 0);
  endtask

  initial begin
    int ws0;
    int rdy_seen;

    vecs[0] = '{n: 288, last_idx: -1, gap: 0, nwr: 18, lmask: 16'h0000, l15: 12'd15};
    vecs[1] = '{n: 21,  last_idx: 20, gap: 0, nwr: 2,  lmask: 16'hFFE0, l15: 12'd15};
    vecs[2] = '{n: 288, last_idx: -1, gap: 3, nwr: 18, lmask: 16'h0000, l15: 12'd15};
    vecs[3] = '{n: 16,  last_idx: 15, gap: 0, nwr: 1,  lmask: 16'h0000, l15: 12'd15};
    vecs[4] = '{n: 1,   last_idx: 0,  gap: 0, nwr: 1,  lmask: 16'hFFFE, l15: 12'd0};

    #2 rst_n = 1'b0;
    repeat (3) step();
    chk_reset_outs("por");
    rst_n = 1'b1;
    repeat (2) step();

    // Reset after beat 7 of address 2: only addresses 0 and 1 may be written.
    pulse_start();
    model_reset();
    drive_beats(0, 39, -1, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_fill");
    chk("rst_fill_pending", W'(exp_q.size()), 0);
    ws0 = writes_seen;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_fill_nowrite", W'(writes_seen - ws0), 0);

    for (int i = 0; i < 5; i++) begin
      ws0 = writes_seen;
      pulse_start();
      chk($sformatf("v%0d_busy", i), W'(busy), 1);
      model_reset();
      drive_beats(0, vecs[i].n, vecs[i].last_idx, vecs[i].gap);
      wait_done();
      chk($sformatf("v%0d_nwr", i), W'(writes_seen - ws0), W'(vecs[i].nwr));
      chk($sformatf("v%0d_lmask", i), W'(last_mask), W'(vecs[i].lmask));
      chk($sformatf("v%0d_done_lat", i), W'(done_cyc - last_wr_cyc), 1);
      chk($sformatf("v%0d_a0_l15", i), W'(a0_data[W-1 -: BW]), W'(vecs[i].l15));
      repeat (3) step();
      chk($sformatf("v%0d_idle_busy", i), W'(busy), 0);
      chk($sformatf("v%0d_q_empty", i), W'(exp_q.size()), 0);
    end

    // Reset lands in the WRITE cycle of address 2, so that write must never reach the SRAM.
    pulse_start();
    model_reset();
    drive_beats(0, 48, -1, 0);
    ws0 = writes_seen;
    chk("rst_wr_active_csb", W'(sram_csb), 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_wr");
    if (exp_q.size() != 0) exp_q.delete(exp_q.size() - 1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("rst_wr_nowrite", W'(writes_seen - ws0), 0);
    chk("rst_wr_q_empty", W'(exp_q.size()), 0);

    // A start pulse during FILL must be ignored. After done, a held in_valid must get no ready.
    ws0 = writes_seen;
    pulse_start();
    model_reset();
    drive_beats(0, 5, -1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    drive_beats(5, 16, 20, 0);
    wait_done();
    in_valid = 1'b1;
    in_data  = 12'hABC;
    rdy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready) rdy_seen++;
      step();
    end
    in_valid = 1'b0;
    chk("restart_nwr", W'(writes_seen - ws0), 2);
    chk("restart_lmask", W'(last_mask), W'(16'hFFE0));
    chk("post_done_ready", W'(rdy_seen), 0);
    chk("post_done_busy", W'(busy), 0);
    chk("post_done_q_empty", W'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
